// File: rtl/microcode_loader.sv
// microcode_loader: writer side of the control store.
// Takes a byte stream over valid/ready, packs little-endian 32-bit control
// words, writes them to consecutive store addresses and closes the load with
// a checksum byte. ctrl_disable holds the control-word bus off while loading.
module microcode_loader #(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_we,
    output logic              ctrl_disable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_CHECK  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    remaining;
    logic [1:0]          idx;
    logic [23:0]         lanes;
    logic                accept_s;

    // Mod-256 accumulation used for both the running sum and the final check.
    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    // A byte transfers on any edge where the handshake completes.
    assign accept_s = in_valid & in_ready;

    // Load sequencer: state, datapath and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr         <= {ADDR_W{1'b0}};
            remaining    <= {CNT_W{1'b0}};
            idx          <= 2'd0;
            lanes        <= 24'd0;
            in_ready     <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_data     <= 32'd0;
            mem_we       <= 1'b0;
            ctrl_disable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            checksum     <= 8'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr         <= base_addr;
                        remaining    <= word_count;
                        checksum     <= 8'd0;
                        error        <= 1'b0;
                        idx          <= 2'd0;
                        busy         <= 1'b1;
                        ctrl_disable <= 1'b1;
                        in_ready     <= 1'b1;
                        if (word_count == {CNT_W{1'b0}}) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        checksum <= sum8(checksum, in_data);
                        idx      <= idx + 2'd1;
                        case (idx)
                            2'd0: lanes[7:0]   <= in_data;
                            2'd1: lanes[15:8]  <= in_data;
                            2'd2: lanes[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word: issue the write.
                                mem_we   <= 1'b1;
                                mem_addr <= addr;
                                mem_data <= {in_data, lanes};
                                in_ready <= 1'b0;
                                state    <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_W.
                    addr      <= addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    in_ready  <= 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state <= S_CHECK;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_CHECK: begin
                    if (accept_s) begin
                        // Checksum byte is compared, never accumulated.
                        error    <= (sum8(checksum, in_data) != 8'd0);
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    busy         <= 1'b0;
                    ctrl_disable <= 1'b0;
                    in_ready     <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    ctrl_disable <= 1'b0;
                    in_ready     <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_loader.sv
// Scoreboard bench for microcode_loader: directed loads push expected writes
// and done-events into queues, a negedge monitor pops and compares them.
module tb_microcode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] base_addr;
    logic [17:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        ctrl_disable;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    microcode_loader #(.ADDR_W(17), .CNT_W(18)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .ctrl_disable(ctrl_disable), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [16:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic err; logic [7:0] sum; } dn_t;

    wr_t         wr_q[$];
    dn_t         dn_q[$];
    logic [7:0]  stream[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        expect_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every write strobe and done pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (expect_busy) chk("ctrl_disable_held", {31'd0, ctrl_disable}, 32'd1);
            if (mem_we) begin
                chk("in_ready_in_write", {31'd0, in_ready}, 32'd0);
                if (wr_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("mem_addr", {15'd0, mem_addr}, {15'd0, w.addr});
                    chk("mem_data", mem_data, w.data);
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("done_error", {31'd0, error}, {31'd0, d.err});
                    chk("done_checksum", {24'd0, checksum}, {24'd0, d.sum});
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ctrl_disable"}, {31'd0, ctrl_disable}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_mem_addr"}, {15'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_data"}, mem_data, 32'd0);
        chk({tag, "_checksum"}, {24'd0, checksum}, 32'd0);
    endtask

    // All driver tasks are entered and left on a falling edge.
    task automatic do_start(input logic [16:0] b, input logic [17:0] c);
        start = 1'b1; base_addr = b; word_count = c;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        chk("error_cleared_by_start", {31'd0, error}, 32'd0);
        expect_busy = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        in_valid = 1'b1; in_data = b;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_vec++; n_bad++;
            $display("FAIL handshake_timeout: got in_ready=0 for %0d cycles expected 1", g);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int maxgap);
        for (int i = 0; i < stream.size(); i++) begin
            if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            send_byte(stream[i]);
        end
    endtask

    // Called in the done cycle right after the checksum byte was accepted.
    task automatic finish_check(input logic exp_err);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_finish", {31'd0, busy}, 32'd1);
        expect_busy = 1'b0;
        @(negedge clk);
        chk("busy_fallen", {31'd0, busy}, 32'd0);
        chk("ctrl_disable_fallen", {31'd0, ctrl_disable}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("error_sticky", {31'd0, error}, {31'd0, exp_err});
    endtask

    task automatic one_word(input logic [16:0] b, input logic [7:0] csb, input logic exp_err);
        stream = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_q.push_back('{addr: b, data: 32'h44332211});
        dn_q.push_back('{err: exp_err, sum: 8'hAA});
        do_start(b, 18'd1);
        send_stream(0);
        chk("checksum_before_check", {24'd0, checksum}, 32'h0000_00AA);
        send_byte(csb);
        finish_check(exp_err);
    endtask

    task automatic three_words(input int maxgap);
        stream = {};
        for (int i = 0; i < 12; i++) stream.push_back(8'hA0 + 8'(i));
        wr_q.push_back('{addr: 17'h00100, data: 32'hA3A2A1A0});
        wr_q.push_back('{addr: 17'h00101, data: 32'hA7A6A5A4});
        wr_q.push_back('{addr: 17'h00102, data: 32'hABAAA9A8});
        dn_q.push_back('{err: 1'b0, sum: 8'hC2});
        do_start(17'h00100, 18'd3);
        send_stream(maxgap);
        send_byte(8'h3E);
        finish_check(1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 17'd0; word_count = 18'd0;
        in_data = 8'd0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // One word, good checksum.
        one_word(17'h00000, 8'h56, 1'b0);

        // Address wrap-around.
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        wr_q.push_back('{addr: 17'h1FFFF, data: 32'h04030201});
        wr_q.push_back('{addr: 17'h00000, data: 32'h08070605});
        dn_q.push_back('{err: 1'b0, sum: 8'h24});
        do_start(17'h1FFFF, 18'd2);
        send_stream(0);
        send_byte(8'hDC);
        finish_check(1'b0);

        // Bad checksum; the following start (in three_words) clears error.
        one_word(17'h00000, 8'h57, 1'b1);
        repeat (2) @(negedge clk);
        chk("error_held_idle", {31'd0, error}, 32'd1);

        // Gap-free and then backpressured 3-word loads.
        three_words(0);
        three_words(3);

        // Reset after 2 of 4 bytes.
        do_start(17'h00050, 18'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        expect_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_write_after_reset", {31'd0, mem_we}, 32'd0);
        one_word(17'h00050, 8'h56, 1'b0);

        // Zero count: straight to checksum.
        dn_q.push_back('{err: 1'b0, sum: 8'h00});
        do_start(17'h0AAAA, 18'd0);
        send_byte(8'h00);
        finish_check(1'b0);

        // Start pulsed during LOAD must not disturb the captured values.
        wr_q.push_back('{addr: 17'h00200, data: 32'h04030201});
        dn_q.push_back('{err: 1'b0, sum: 8'h0A});
        do_start(17'h00200, 18'd1);
        send_byte(8'h01);
        start = 1'b1; base_addr = 17'h01234; word_count = 18'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'hF6);
        finish_check(1'b0);

        repeat (3) @(negedge clk);
        chk("writes_all_seen", wr_q.size(), 32'd0);
        chk("dones_all_seen", dn_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/microcode_loader.md
# microcode_loader

Writer side of the control store. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit control words. Each word is written into control-store RAM at consecutive addresses, and the load ends with a verified checksum byte. While loading it drives `ctrl_disable` high; that line feeds the control logic's `ctrlen`, so the control-word bus stays tristated while the store is being rewritten.

## Interface
Parameters:
- ADDR_W, 17: control-store address width; address = {ext, opcode[7:0], flags[3:0], step[3:0]}, step is the LSBs.
- CNT_W, 18: width of `word_count`; must hold 2^ADDR_W.

Ports:
- clk  in  1  single clock, all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first store address; captured on accepted `start`.
- word_count  in  CNT_W  number of 32-bit words; captured on accepted `start`; 0 is legal.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  loader can take a byte.
- mem_addr  out  ADDR_W  store write address.
- mem_data  out  32  store write data.
- mem_we  out  1  one-cycle write strobe.
- ctrl_disable  out  1  high while busy, for `ctrlen`.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse at end of load.
- error  out  1  checksum mismatch; sticky until next accepted `start` or `rst`.
- checksum  out  8  running mod-256 sum of data bytes; the checksum byte is excluded.

## Operation
- A byte is accepted on a rising edge where `in_valid & in_ready` holds.
- States:
  - IDLE: `in_ready`=0. On `start`: capture `base_addr` and `word_count`, clear `checksum`, `error` and the byte index, then go to LOAD, or to CHECK if `word_count`==0.
  - LOAD: `in_ready`=1. Each accepted byte goes to lane `idx` of the word: the first byte fills [7:0], the fourth fills [31:24]. Each accepted byte is added to `checksum`. On the 4th byte go to WRITE.
  - WRITE: exactly 1 cycle. `mem_we`=1, `mem_addr`=current address, `mem_data`=assembled word, `in_ready`=0. Next, the address increments modulo 2^ADDR_W (0x1FFFF wraps to 0x00000) and the remaining count decrements. If the remaining count is 0, go to CHECK, else go to LOAD.
  - CHECK: `in_ready`=1. On an accepted byte b, set `error` = ((`checksum` + b) mod 256 != 0), then go to FINISH.
  - FINISH: 1 cycle. `done`=1, then go to IDLE.
- `busy` = `ctrl_disable` = (state != IDLE).
- `start` is ignored in every state except IDLE.
- `mem_addr` and `mem_data` hold their last values outside WRITE. They are don't-care when `mem_we`=0.
- `rst` behaviour:
  - Any state goes to IDLE.
  - All outputs return to their reset values.
  - A partial word is discarded and no write is issued.
  - `rst` has priority over `start` in the same cycle.

## Timing
- Reset values:
  - `in_ready`, `mem_we`, `busy`, `ctrl_disable`, `done`, `error` = 0.
  - `mem_addr` = 0, `mem_data` = 0, `checksum` = 0.
- `start` sampled at edge N: `busy`, `ctrl_disable` and `in_ready` are high from N+1.
- 4th byte accepted at edge M: `mem_we` is high for the cycle after M, and `in_ready` is low in that cycle.
- Maximum throughput is 1 word per 5 cycles. Gaps in `in_valid` only stretch LOAD and CHECK.
- Checksum byte accepted at edge K:
  - `error` is valid from K+1.
  - `done` is high for the cycle after K.
  - `busy` falls at K+2.
- `in_ready` depends only on state, never combinationally on `in_valid`.

## Test plan
- One word: base 0x00000, count 1, bytes 0x11,0x22,0x33,0x44, checksum 0x56.
  - Exactly one `mem_we` with addr 0x00000, data 0x44332211.
  - `checksum`=0xAA, then `done` pulses with `error`=0.
- Wrap-around: base 0x1FFFF, count 2, 8 bytes plus a correct checksum byte.
  - Writes go to 0x1FFFF, then 0x00000.
  - `ctrl_disable` stays high from start+1 until `busy` falls.
- Bad checksum: same stream as the one-word test, but the checksum byte is 0x57.
  - `error`=1 after `done`; `checksum`=0xAA.
  - The next `start` clears `error`.
- Backpressure: `in_valid` toggles randomly on a 3-word load.
  - Identical writes to a gap-free run and no byte lost.
  - `in_ready`=0 during every WRITE cycle.
- Reset mid-word: `rst` after 2 of 4 bytes.
  - Next cycle all outputs are at reset values and no `mem_we` occurs.
  - A following one-word load completes correctly.
- Zero count and start while busy: count 0 with checksum byte 0x00 gives no writes, `done`, `error`=0. A `start` pulsed during LOAD changes no captured value.
